// File: rtl/vdp_obj_linebuf.sv
// rtl/vdp_obj_linebuf.sv - double-buffered sprite line buffer with first-opaque-wins writes and clear-on-read
module vdp_obj_linebuf #(
    parameter int AW            = 9,
    parameter int DW            = 8,
    parameter int TW            = 4,
    parameter bit CLEAR_ON_READ = 1'b1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          swap,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          collision,
    output logic          busy,
    output logic          wbank
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t        state;
    logic [AW-1:0] init_addr;

    logic [DW-1:0] bank0 [DEPTH];
    logic [DW-1:0] bank1 [DEPTH];

    // Stage-2 write: captured request plus the old pixel it merges against.
    logic          s2w_valid;
    logic [AW-1:0] s2w_addr;
    logic [DW-1:0] s2w_data;
    logic [DW-1:0] s2w_old;
    logic          s2w_bank;

    // Stage-2 clear left behind by a read.
    logic          s2c_valid;
    logic [AW-1:0] s2c_addr;
    logic          s2c_bank;

    logic          run;
    logic          wr_go;
    logic          rd_go;
    logic          new_opaque;
    logic          old_opaque;
    logic          s2w_commit;
    logic [DW-1:0] s2w_result;
    logic          wr_fwd;
    logic          rd_fwd;

    function automatic logic is_opaque(input logic [TW-1:0] t);
        return |t;
    endfunction

    assign run        = (state == S_RUN);
    // Swap wins over both requests in the same cycle.
    assign wr_go      = run && wr_en && !swap;
    assign rd_go      = run && rd_en && !swap;

    assign new_opaque = is_opaque(s2w_data[TW-1:0]);
    assign old_opaque = is_opaque(s2w_old[TW-1:0]);
    assign s2w_commit = s2w_valid && new_opaque && !old_opaque;
    // Pixel value that will sit in RAM once stage 2 retires.
    assign s2w_result = s2w_commit ? s2w_data : s2w_old;
    assign collision  = s2w_valid && new_opaque && old_opaque;

    // The RAM read at stage 1 is stale when stage 2 is updating the same pixel this cycle.
    assign wr_fwd     = s2w_valid && (s2w_addr == wr_addr) && (s2w_bank == wbank);
    // A read that lands on the pixel being cleared this cycle must see the cleared value.
    assign rd_fwd     = s2c_valid && (s2c_addr == rd_addr) && (s2c_bank == !wbank);

    // Sequencer: INIT sweeps every address once, RUN owns the bank swap.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_INIT;
            init_addr <= '0;
            busy      <= 1'b1;
            wbank     <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    init_addr <= init_addr + 1'b1;
                    if (&init_addr) begin
                        state <= S_RUN;
                        busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (swap) begin
                        wbank <= !wbank;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    // Pipeline registers for the write merge, the clear-on-read and the read data.
    always_ff @(posedge clock) begin
        if (reset) begin
            s2w_valid <= 1'b0;
            s2w_addr  <= '0;
            s2w_data  <= '0;
            s2w_old   <= '0;
            s2w_bank  <= 1'b0;
            s2c_valid <= 1'b0;
            s2c_addr  <= '0;
            s2c_bank  <= 1'b0;
            rd_data   <= '0;
        end else begin
            s2w_valid <= wr_go;
            s2w_addr  <= wr_addr;
            s2w_data  <= wr_data;
            s2w_bank  <= wbank;
            if (wr_fwd) begin
                s2w_old <= s2w_result;
            end else begin
                s2w_old <= wbank ? bank1[wr_addr] : bank0[wr_addr];
            end

            s2c_valid <= rd_go && CLEAR_ON_READ;
            s2c_addr  <= rd_addr;
            s2c_bank  <= !wbank;

            if (rd_go) begin
                if (rd_fwd) begin
                    rd_data <= '0;
                end else begin
                    rd_data <= wbank ? bank0[rd_addr] : bank1[rd_addr];
                end
            end
        end
    end

    // Bank writes: the write commit and the read clear always land in opposite banks.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == S_INIT) begin
                bank0[init_addr] <= '0;
                bank1[init_addr] <= '0;
            end else begin
                if (s2w_commit) begin
                    if (s2w_bank) begin
                        bank1[s2w_addr] <= s2w_data;
                    end else begin
                        bank0[s2w_addr] <= s2w_data;
                    end
                end
                if (s2c_valid) begin
                    if (s2c_bank) begin
                        bank1[s2c_addr] <= '0;
                    end else begin
                        bank0[s2c_addr] <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vdp_obj_linebuf.sv
// tb/tb_vdp_obj_linebuf.sv - self-checking bench for vdp_obj_linebuf
module tb_vdp_obj_linebuf;

    localparam int AW    = 9;
    localparam int DW    = 8;
    localparam int TW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clock   = 1'b0;
    logic          reset   = 1'b1;
    logic          swap    = 1'b0;
    logic          wr_en   = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en   = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          collision;
    logic          busy;
    logic          wbank;

    vdp_obj_linebuf #(
        .AW(AW),
        .DW(DW),
        .TW(TW),
        .CLEAR_ON_READ(1'b1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .swap(swap),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .collision(collision),
        .busy(busy),
        .wbank(wbank)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          sw;
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          re;
        logic [AW-1:0] ra;
        logic [DW-1:0] e_rd;
        logic          e_col;
        logic          e_wb;
    } vec_t;

    vec_t tab[$];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: both banks as plain arrays, every request applied at once in issue order.
    logic [DW-1:0] m_mem [2][DEPTH];
    logic          m_wbank;
    logic [DW-1:0] exp_rd;
    logic          exp_col;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < DEPTH; a++) begin
                m_mem[b][a] = '0;
            end
        end
        m_wbank = 1'b0;
        exp_rd  = '0;
        exp_col = 1'b0;
    endfunction

    function automatic void add(input logic sw, input logic we, input logic [AW-1:0] wa,
                                input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra,
                                input logic [DW-1:0] e_rd, input logic e_col, input logic e_wb);
        vec_t v;
        v.sw = sw; v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
        v.e_rd = e_rd; v.e_col = e_col; v.e_wb = e_wb;
        tab.push_back(v);
    endfunction

    // Drive one cycle of requests, update the model, and land on the next falling edge.
    task automatic apply(input logic sw, input logic we, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra);
        logic [DW-1:0] old;
        swap    = sw;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_en   = re;
        rd_addr = ra;
        exp_col = 1'b0;
        if (sw) begin
            m_wbank = ~m_wbank;
        end else begin
            if (we) begin
                old = m_mem[m_wbank][wa];
                if (wd[TW-1:0] != '0) begin
                    if (old[TW-1:0] != '0) exp_col = 1'b1;
                    else m_mem[m_wbank][wa] = wd;
                end
            end
            if (re) begin
                exp_rd = m_mem[~m_wbank][ra];
                m_mem[~m_wbank][ra] = '0;
            end
        end
        @(posedge clock);
        @(negedge clock);
        swap  = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_rd_data"}, int'(rd_data), int'(exp_rd));
        check({tag, "_collision"}, int'(collision), int'(exp_col));
        check({tag, "_wbank"}, int'(wbank), int'(m_wbank));
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic run_reset(input string tag);
        int cnt;
        reset = 1'b1;
        swap  = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        repeat (3) begin
            @(posedge clock);
            @(negedge clock);
        end
        check({tag, "_rst_rd_data"}, int'(rd_data), 0);
        check({tag, "_rst_collision"}, int'(collision), 0);
        check({tag, "_rst_busy"}, int'(busy), 1);
        check({tag, "_rst_wbank"}, int'(wbank), 0);
        reset = 1'b0;
        cnt = 0;
        while (busy && cnt < 2000) begin
            cnt++;
            @(posedge clock);
            @(negedge clock);
        end
        check({tag, "_busy_cycles"}, cnt, DEPTH);
        check({tag, "_post_wbank"}, int'(wbank), 0);
        model_clear();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //   sw    we    wa      wd      re    ra      e_rd    e_col e_wb
        add(1'b0, 1'b1, 9'd10, 8'h21, 1'b0, 9'd0,  8'h00, 1'b0, 1'b0);
        add(1'b0, 1'b1, 9'd10, 8'h35, 1'b0, 9'd0,  8'h00, 1'b1, 1'b0);
        add(1'b0, 1'b1, 9'd5,  8'h30, 1'b0, 9'd0,  8'h00, 1'b0, 1'b0);
        add(1'b0, 1'b1, 9'd5,  8'h17, 1'b0, 9'd0,  8'h00, 1'b0, 1'b0);
        add(1'b0, 1'b1, 9'd20, 8'h44, 1'b0, 9'd0,  8'h00, 1'b0, 1'b0);
        add(1'b1, 1'b0, 9'd0,  8'h00, 1'b0, 9'd0,  8'h00, 1'b0, 1'b1);
        add(1'b0, 1'b0, 9'd0,  8'h00, 1'b1, 9'd10, 8'h21, 1'b0, 1'b1);
        add(1'b0, 1'b0, 9'd0,  8'h00, 1'b1, 9'd5,  8'h17, 1'b0, 1'b1);
        add(1'b0, 1'b0, 9'd0,  8'h00, 1'b1, 9'd20, 8'h44, 1'b0, 1'b1);
        add(1'b0, 1'b0, 9'd0,  8'h00, 1'b1, 9'd20, 8'h00, 1'b0, 1'b1);
        add(1'b0, 1'b0, 9'd0,  8'h00, 1'b1, 9'd10, 8'h00, 1'b0, 1'b1);
        add(1'b1, 1'b1, 9'd3,  8'h11, 1'b0, 9'd0,  8'h00, 1'b0, 1'b0);
        add(1'b0, 1'b0, 9'd0,  8'h00, 1'b1, 9'd3,  8'h00, 1'b0, 1'b0);
        add(1'b0, 1'b1, 9'd7,  8'h0A, 1'b1, 9'd7,  8'h00, 1'b0, 1'b0);
        add(1'b1, 1'b0, 9'd0,  8'h00, 1'b0, 9'd0,  8'h00, 1'b0, 1'b1);
        add(1'b0, 1'b0, 9'd0,  8'h00, 1'b1, 9'd7,  8'h0A, 1'b0, 1'b1);
        add(1'b0, 1'b1, 9'd7,  8'h0B, 1'b1, 9'd7,  8'h00, 1'b0, 1'b1);
        add(1'b1, 1'b0, 9'd0,  8'h00, 1'b0, 9'd0,  8'h00, 1'b0, 1'b0);
        add(1'b0, 1'b0, 9'd0,  8'h00, 1'b1, 9'd7,  8'h0B, 1'b0, 1'b0);
        add(1'b0, 1'b0, 9'd0,  8'h00, 1'b0, 9'd0,  8'h0B, 1'b0, 1'b0);

        run_reset("init");

        foreach (tab[i]) begin
            apply(tab[i].sw, tab[i].we, tab[i].wa, tab[i].wd, tab[i].re, tab[i].ra);
            check($sformatf("tab%0d_rd_data", i), int'(rd_data), int'(tab[i].e_rd));
            check($sformatf("tab%0d_collision", i), int'(collision), int'(tab[i].e_col));
            check($sformatf("tab%0d_wbank", i), int'(wbank), int'(tab[i].e_wb));
        end

        for (int n = 0; n < 3000; n++) begin
            logic          sw;
            logic          we;
            logic          re;
            logic [AW-1:0] wa;
            logic [AW-1:0] ra;
            logic [DW-1:0] wd;
            sw = ($urandom_range(15) == 0);
            we = 1'($urandom_range(1));
            re = 1'($urandom_range(1));
            wa = ($urandom_range(3) == 0) ? AW'($urandom) : AW'($urandom_range(15));
            ra = ($urandom_range(3) == 0) ? AW'($urandom) : AW'($urandom_range(15));
            wd = DW'($urandom);
            if ($urandom_range(3) == 0) wd[TW-1:0] = '0;
            apply(sw, we, wa, wd, re, ra);
            check_model($sformatf("rnd%0d", n));
        end

        if (m_wbank == 1'b0) begin
            apply(1'b1, 1'b0, '0, '0, 1'b0, '0);
            check_model("pre_reset_swap");
        end
        apply(1'b0, 1'b1, 9'd4, 8'h5A, 1'b0, '0);
        apply(1'b0, 1'b1, 9'd9, 8'h6C, 1'b0, '0);
        run_reset("midline");

        for (int a = 0; a < DEPTH; a++) begin
            apply(1'b0, 1'b0, '0, '0, 1'b1, AW'(a));
            check_model($sformatf("sweep1_%0d", a));
        end
        apply(1'b1, 1'b0, '0, '0, 1'b0, '0);
        check_model("sweep_swap");
        for (int a = 0; a < DEPTH; a++) begin
            apply(1'b0, 1'b0, '0, '0, 1'b1, AW'(a));
            check_model($sformatf("sweep0_%0d", a));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
